spmv_row_feeder: RTL
====================

// Module: spmv_row_feeder
// PURPOSE
// Drives the operand side of the SpMV dot-product kernel. Consumes CSR row pointers, nonzero values and
// pre-gathered x[col] values; emits per-row nnz counts on TIMES plus lockstep A (value) / B (x) pairs.
// Empty rows get one padded 0.0*0.0 pair with TIMES=1, so the kernel emits exactly one result per row.
// Sits between the CSR/x fetch logic and the multiply/accumulate datapath.
// PARAMETERS
// CNT_W   32   width of row pointers, TIMES data, row and element counters
// PORTS
// clk                  in   1      sole clock
// rst                  in   1      asynchronous, active-high reset
// start                in   1      1-cycle pulse; begins a job; ignored while busy
// cfg_rows             in   CNT_W  row count N; sampled on start
// busy                 out  1      high from accepted start until done
// done                 out  1      1-cycle pulse after last pair of row N-1 is handshaken
// err                  out  1      sticky: non-monotonic row pointer seen; cleared on start
// S_AXIS_RPTR_tdata    in   CNT_W  row_ptr[0..N], N+1 words per job
// S_AXIS_RPTR_tvalid   in   1
// S_AXIS_RPTR_tready   out  1
// S_AXIS_VAL_tdata     in   64     fp64 nonzero value, CSR order
// S_AXIS_VAL_tvalid    in   1
// S_AXIS_VAL_tready    out  1
// S_AXIS_X_tdata       in   64     fp64 x[col], same order as VAL
// S_AXIS_X_tvalid      in   1
// S_AXIS_X_tready      out  1
// M_AXIS_TIMES_tdata   out  CNT_W  elements in this row (>=1)
// M_AXIS_TIMES_tvalid  out  1
// M_AXIS_TIMES_tready  in   1
// M_AXIS_A_tdata / M_AXIS_A_tvalid / M_AXIS_A_tready        out 64 / out 1 / in 1  value to multiplier
// M_AXIS_B_tdata / M_AXIS_B_tvalid / M_AXIS_B_tready        out 64 / out 1 / in 1  x to multiplier
// BEHAVIOUR
// - Reset: state IDLE, all tvalid/tready 0, busy/done/err 0, counters 0, output data 0.
// - FSM: IDLE -start-> BASE (take row_ptr[0] into prev) -> PTR (take row_ptr[r+1]; nnz=cur-prev; prev=cur)
//   -> TIMES -> PAIRS | PAD -> row r++: r==N ? DONE : PTR. DONE pulses done for 1 cycle -> IDLE.
// - start with cfg_rows==0: BASE still consumes row_ptr[0]; next cycle DONE.
// - cur<prev: err<=1, row treated as empty; prev still updated to cur.
// - TIMES: tdata = nnz, or 1 if nnz==0; tvalid held with stable data until tready; never depends on tready.
// - PAIRS: remaining=nnz; output slice holds one (A,B) pair. Slice loads only when both sides empty and
//   VAL & X both valid; VAL/X tready asserted together in that cycle only. A and B valid rise together and
//   each drops independently on its own handshake. remaining decrements on load; exit when remaining==0
//   and slice empty.
// - PAD: load A=B=64'h0 into slice without consuming VAL/X; exit when slice empty.
// - Ordering: TIMES of row r handshaken before first pair of row r; all pairs of row r handshaken before
//   RPTR word for row r+1 is accepted. Pair throughput 1/cycle when readies held high.
// - RPTR tready high only in BASE/PTR; VAL/X tready never high outside PAIRS.
// - rst mid-job: immediate return to IDLE, outputs dropped; partially consumed inputs are not replayed.
// TESTING
// - N=2, row_ptr {0,2,5}, readies high -> TIMES 2,3; 5 pairs in order; done pulse; err=0.
// - N=3, row_ptr {4,4,6,6} -> TIMES 1,2,1; pairs (0,0),(v0,x0),(v1,x1),(0,0); VAL/X consume exactly 2.
// - A_tready toggled 1010, B_tready 0110 -> no pair lost/duplicated; a new pair loads only after both drain.
// - row_ptr {0,3,1}, N=2 -> err=1; row1 TIMES=1 padded; err cleared by next start.
// - cfg_rows=0 -> one RPTR word consumed, done 2 cycles after start, no TIMES/A/B.
// - rst asserted during PAIRS -> all tvalid 0 same cycle; fresh start completes a full job correctly.

Source files
------------

// File: rtl/spmv_row_feeder.sv
// CSR row feeder: turns row pointers plus VAL/X streams into per-row TIMES and lockstep A/B pairs.
// TIMES is registered one cycle after its RPTR word; pairs stream at 1/cycle; every stream waits on its own ready.
module spmv_row_feeder #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_rows,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [CNT_W-1:0] S_AXIS_RPTR_tdata,
  input  logic             S_AXIS_RPTR_tvalid,
  output logic             S_AXIS_RPTR_tready,
  input  logic [63:0]      S_AXIS_VAL_tdata,
  input  logic             S_AXIS_VAL_tvalid,
  output logic             S_AXIS_VAL_tready,
  input  logic [63:0]      S_AXIS_X_tdata,
  input  logic             S_AXIS_X_tvalid,
  output logic             S_AXIS_X_tready,
  output logic [CNT_W-1:0] M_AXIS_TIMES_tdata,
  output logic             M_AXIS_TIMES_tvalid,
  input  logic             M_AXIS_TIMES_tready,
  output logic [63:0]      M_AXIS_A_tdata,
  output logic             M_AXIS_A_tvalid,
  input  logic             M_AXIS_A_tready,
  output logic [63:0]      M_AXIS_B_tdata,
  output logic             M_AXIS_B_tvalid,
  input  logic             M_AXIS_B_tready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BASE  = 3'd1;
  localparam logic [2:0] S_PTR   = 3'd2;
  localparam logic [2:0] S_TIMES = 3'd3;
  localparam logic [2:0] S_PAIRS = 3'd4;
  localparam logic [2:0] S_PAD   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]       state;
  logic [CNT_W-1:0] rows;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] prev;
  logic [CNT_W-1:0] remaining;
  logic             times_vld;
  logic [CNT_W-1:0] times_dat;
  logic             a_vld;
  logic             b_vld;
  logic [63:0]      a_dat;
  logic [63:0]      b_dat;

  logic             rptr_fire;
  logic             times_fire;
  logic             a_fire;
  logic             b_fire;
  logic             slice_free;
  logic             pair_load;
  logic             ptr_desc;
  logic [CNT_W-1:0] ptr_nnz;
  logic             row_last;

  assign rptr_fire  = S_AXIS_RPTR_tvalid && S_AXIS_RPTR_tready;
  assign times_fire = times_vld && M_AXIS_TIMES_tready;
  assign a_fire     = a_vld && M_AXIS_A_tready;
  assign b_fire     = b_vld && M_AXIS_B_tready;
  // Slice counts as empty when each side is either idle or draining this cycle.
  assign slice_free = (!a_vld || a_fire) && (!b_vld || b_fire);
  assign pair_load  = (state == S_PAIRS) && slice_free && (remaining != '0) &&
                      S_AXIS_VAL_tvalid && S_AXIS_X_tvalid;
  assign ptr_desc   = S_AXIS_RPTR_tdata < prev;
  assign ptr_nnz    = ptr_desc ? '0 : (S_AXIS_RPTR_tdata - prev);
  assign row_last   = (row + CNT_W'(1)) == rows;

  assign S_AXIS_RPTR_tready  = (state == S_BASE) || (state == S_PTR);
  assign S_AXIS_VAL_tready   = pair_load;
  assign S_AXIS_X_tready     = pair_load;
  assign M_AXIS_TIMES_tdata  = times_dat;
  assign M_AXIS_TIMES_tvalid = times_vld;
  assign M_AXIS_A_tdata      = a_dat;
  assign M_AXIS_A_tvalid     = a_vld;
  assign M_AXIS_B_tdata      = b_dat;
  assign M_AXIS_B_tvalid     = b_vld;
  assign busy                = state != S_IDLE;
  assign done                = state == S_DONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rows      <= '0;
      row       <= '0;
      prev      <= '0;
      remaining <= '0;
      err       <= 1'b0;
      times_vld <= 1'b0;
      times_dat <= '0;
      a_vld     <= 1'b0;
      b_vld     <= 1'b0;
      a_dat     <= '0;
      b_dat     <= '0;
    end else begin
      if (a_fire) a_vld <= 1'b0;
      if (b_fire) b_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rows  <= cfg_rows;
            row   <= '0;
            err   <= 1'b0;
            state <= S_BASE;
          end
        end
        S_BASE: begin
          if (rptr_fire) begin
            prev  <= S_AXIS_RPTR_tdata;
            state <= (rows == '0) ? S_DONE : S_PTR;
          end
        end
        S_PTR: begin
          if (rptr_fire) begin
            prev      <= S_AXIS_RPTR_tdata;
            remaining <= ptr_nnz;
            times_dat <= (ptr_nnz == '0) ? CNT_W'(1) : ptr_nnz;
            times_vld <= 1'b1;
            if (ptr_desc) err <= 1'b1;
            state <= S_TIMES;
          end
        end
        S_TIMES: begin
          if (times_fire) begin
            times_vld <= 1'b0;
            if (remaining == '0) begin
              // Empty row: the single 0.0*0.0 pair is loaded as PAD is entered.
              a_vld <= 1'b1;
              b_vld <= 1'b1;
              a_dat <= '0;
              b_dat <= '0;
              state <= S_PAD;
            end else begin
              state <= S_PAIRS;
            end
          end
        end
        S_PAIRS: begin
          if (pair_load) begin
            a_vld     <= 1'b1;
            b_vld     <= 1'b1;
            a_dat     <= S_AXIS_VAL_tdata;
            b_dat     <= S_AXIS_X_tdata;
            remaining <= remaining - CNT_W'(1);
          end else if ((remaining == '0) && slice_free) begin
            row   <= row + CNT_W'(1);
            state <= row_last ? S_DONE : S_PTR;
          end
        end
        S_PAD: begin
          if (slice_free) begin
            row   <= row + CNT_W'(1);
            state <= row_last ? S_DONE : S_PTR;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
